cassette_player: RTL
====================

Name: cassette_player

Overview:
- Parametrised tape-playback engine for CoCo cassette images (.CAS) held in SDRAM.
- Fetches bytes through a request/acknowledge memory port with a one-byte prefetch buffer.
- Serialises each byte LSB-first into CoCo FSK on cas_out: one 2400 Hz cycle per '1' bit, one 1200 Hz cycle per '0' bit.
- Inserts a silent gap after the filename block, stops after the EOF block or at end_addr, and honours the cassette motor relay. Feeds the cassette-in comparator path.

Parameters:
- ADDR_W, 25, width of mem_addr and end_addr.
- HALF1, 185, ce ticks per half-cycle of a '1' bit (2400 Hz at 0.89 MHz ce).
- HALF0, 371, ce ticks per half-cycle of a '0' bit (1200 Hz).
- GAP_TICKS, 445000, ce ticks of silence inserted after the filename block (0.5 s).
- CNT_W, 19, width of the gap and half-period counters; must hold GAP_TICKS.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- ce, in, 1, timing tick; all waveform and gap counting advances only on ce=1.
- play, in, 1, play/pause toggle, acting on its rising edge.
- rewind, in, 1, rewind, acting on its rising edge.
- motor, in, 1, motor relay; 0 freezes playback.
- end_addr, in, ADDR_W, exclusive end address of the image.
- mem_addr, out, ADDR_W, byte address.
- mem_rd, out, 1, read request.
- mem_ack, in, 1, one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data, in, 8, read data.
- cas_out, out, 1, FSK bit stream.
- status, out, 3, state: 0 IDLE, 1 RUN, 2 GAP, 3 DONE, 4 STALL.
- underrun, out, 1, sticky; set when the shifter needs a byte and the buffer is empty.

Behaviour:
- Reset:
  - State IDLE; mem_addr=0; mem_rd=0; cas_out=0; underrun=0.
  - Buffer and shifter empty; 3-byte history window cleared to 0; name_seen=0; eof_armed=0.
- Edge detection: play and rewind are registered on every clk, independent of ce.
- Play rising edge:
  - IDLE→RUN.
  - RUN, GAP or STALL→IDLE (pause). Address, buffer, shifter, counters and flags are kept; cas_out is forced to 0.
  - DONE: ignored.
- Rewind rising edge, from any state:
  - State IDLE; mem_addr=0; buffer and shifter flushed; window, name_seen, eof_armed and underrun cleared; cas_out=0.
  - If play and rewind rise in the same cycle, rewind wins.
- Memory handshake (clk domain, not ce-gated):
  - mem_rd goes high when state is RUN/GAP/STALL, the buffer is empty and mem_addr≠end_addr.
  - mem_rd and mem_addr stay stable until mem_ack.
  - On mem_ack: mem_rd=0, buffer←mem_data, mem_addr+1.
  - A read in flight when rewind or pause occurs is allowed to complete. After rewind its data is discarded and mem_addr stays 0. After pause the data is kept.
  - mem_rd is never asserted in IDLE or DONE.
- Shifter:
  - When the shifter empties, the buffer byte B moves into it in the same clk and the buffer frees.
  - On that load, the byte is checked against window {w2,w1,B}:
    - If name_seen and w2=w1=B=0x55: enter GAP and clear name_seen.
    - If {w2,w1,B}=55 3C 00: set name_seen.
    - If {w2,w1,B}=55 3C FF: set eof_armed.
  - The window then shifts to {w1,B}.
- Bit timing: for bit b, cas_out=1 for H ticks, then 0 for H ticks, with H=HALF1 if b else HALF0. Bits go out LSB first, 8 bits per byte, with no idle between bytes while data is available.
- Underrun: if the shifter is empty with no buffered byte and mem_addr≠end_addr, set underrun and hold cas_out=0 until data arrives.
- GAP:
  - cas_out=0 for GAP_TICKS ce ticks, then return to RUN and emit the held byte (the third 0x55).
  - Prefetch continues during GAP.
- EOF: if eof_armed and the byte just finished completed window 00 FF 55, go to DONE after its last half-cycle.
- End of image: when mem_addr=end_addr and both buffer and shifter are empty, go to DONE.
- DONE: cas_out=0; only rewind leaves it.
- STALL:
  - Entered from RUN or GAP whenever motor=0. All ce counters freeze and cas_out holds its value.
  - Exits to the prior state when motor=1.
  - Fetching continues during STALL.
- Counter widths: all counters are CNT_W; mem_addr wraps modulo 2^ADDR_W.

Test Plan:
- Image bytes {0x01} with end_addr=1, HALF1=2, HALF0=4, ce=1. Pulse play → cas_out is 1 for 2, 0 for 2, then seven repetitions of 1 for 4, 0 for 4; then status=3. mem_rd is asserted exactly once, at address 0.
- Image 55 3C 00 … 55 55 55 A5 with GAP_TICKS=10 → on loading the third 0x55, status=2 and cas_out=0 for 10 ticks. Then the 0x55 bits resume unchanged and the later bytes follow with no second gap.
- Image with header 55 3C FF 00 FF 55 followed by 4 extra bytes → DONE after the trailer 0x55. The extra bytes are never emitted, and at most 1 extra fetch is issued.
- mem_ack delayed 50 clk with ce=1 and HALF1=2 → underrun=1 and cas_out=0 during the stall; the waveform resumes once ack arrives.
- Drop motor mid-bit for 20 ticks → status=4 and cas_out frozen; the remaining half-period completes after motor=1, and total byte duration grows by exactly 20 ticks.
- Rewind asserted while mem_rd=1, with ack 3 clk later → ack data is not emitted, mem_addr=0, status=0. The next play fetches address 0.

Source files
------------

// File: rtl/cassette_player.sv
// ---------------------------------------------------------------------------
// cassette_player
//   Plays a CoCo cassette image (.CAS) held in byte-addressed memory as a
//   FSK bit stream. Bytes are fetched through a request/acknowledge port into
//   a one-byte prefetch buffer, moved into a shifter and sent LSB first: one
//   2400 Hz cycle per '1' bit, one 1200 Hz cycle per '0' bit. A silent gap is
//   inserted after the filename block, playback stops after the EOF block or
//   at end_addr, and the motor relay freezes the waveform.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   ce                  timing tick; waveform and gap counters advance only on ce
//   play, rewind        rising-edge controls (play toggles run/pause)
//   motor               cassette motor relay, 0 stalls playback
//   end_addr            exclusive end address of the image
//   mem_addr, mem_rd    read request (held stable until mem_ack)
//   mem_ack, mem_data   one-cycle acknowledge with data valid in that cycle
//   cas_out             FSK output
//   status              0 IDLE, 1 RUN, 2 GAP, 3 DONE, 4 STALL
//   underrun            sticky, shifter starved while image data remains
// ---------------------------------------------------------------------------
module cassette_player #(
  parameter int ADDR_W    = 25,
  parameter int HALF1     = 185,
  parameter int HALF0     = 371,
  parameter int GAP_TICKS = 445000,
  parameter int CNT_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              play,
  input  logic              rewind,
  input  logic              motor,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              cas_out,
  output logic [2:0]        status,
  output logic              underrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_STALL = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] H1_LAST  = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] H0_LAST  = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  state_t           state, state_next, resume_state, eff_state;
  logic             play_q, rewind_q, play_rise, rew_rise, user_evt;
  logic             discard;
  logic             buf_valid;
  logic [7:0]       buf_data;
  logic             sh_valid, sh_eof, phase;
  logic [7:0]       sh_data;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt, gap_cnt, half_last;
  logic [7:0]       w1, w2;
  logic             name_seen, eof_armed;
  logic             run_act, gap_act, half_end, byte_done, eof_stop;
  logic             load, win_gap, gap_done, end_image, fetch_ok;

  assign play_rise = play & ~play_q;
  assign rew_rise  = rewind & ~rewind_q;
  assign user_evt  = rew_rise | (play_rise & (state != S_DONE));

  // While stalled, the datapath behaves as the state it will return to, so
  // the tick on which the motor comes back already counts.
  assign eff_state = (state == S_STALL) ? resume_state : state;
  assign run_act   = motor & ~user_evt & (eff_state == S_RUN);
  assign gap_act   = motor & ~user_evt & (eff_state == S_GAP);

  assign half_last = sh_data[0] ? H1_LAST : H0_LAST;
  assign half_end  = ce & run_act & sh_valid & (cnt == half_last);
  assign byte_done = half_end & phase & (bit_idx == 3'd7);
  assign eof_stop  = byte_done & sh_eof;
  assign load      = run_act & buf_valid & ~eof_stop & (~sh_valid | byte_done);
  assign win_gap   = name_seen & (w2 == 8'h55) & (w1 == 8'h55) & (buf_data == 8'h55);
  assign gap_done  = ce & gap_act & (gap_cnt == GAP_LAST);
  assign end_image = run_act & ~sh_valid & ~buf_valid & (mem_addr == end_addr);
  assign fetch_ok  = state_next inside {S_RUN, S_GAP, S_STALL};

  assign cas_out = sh_valid & ~phase & (eff_state == S_RUN);
  assign status  = state;

  // Next-state logic: rewind beats play, play toggles run/pause, and a low
  // motor overrides whatever the run/gap logic would do.
  always_comb begin
    state_next = state;
    if (rew_rise) begin
      state_next = S_IDLE;
    end else if (play_rise && state != S_DONE) begin
      state_next = (state == S_IDLE) ? S_RUN : S_IDLE;
    end else if (state inside {S_RUN, S_GAP, S_STALL}) begin
      if (!motor) begin
        state_next = S_STALL;
      end else if (eff_state == S_RUN) begin
        if (eof_stop || end_image)
          state_next = S_DONE;
        else if (load && win_gap)
          state_next = S_GAP;
        else
          state_next = S_RUN;
      end else begin
        state_next = gap_done ? S_RUN : S_GAP;
      end
    end
  end

  // State register; resume_state remembers RUN or GAP for leaving STALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      resume_state <= S_RUN;
    end else begin
      state <= state_next;
      if (state == S_RUN || state == S_GAP)
        resume_state <= state;
    end
  end

  // Fetch path, prefetch buffer, shifter, bit timing, gap timer and the
  // header window. A read outstanding at rewind finishes normally but its
  // data is dropped and the address returns to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      play_q    <= 1'b0;
      rewind_q  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      discard   <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= 8'h00;
      sh_valid  <= 1'b0;
      sh_eof    <= 1'b0;
      sh_data   <= 8'h00;
      phase     <= 1'b0;
      bit_idx   <= 3'd0;
      cnt       <= '0;
      gap_cnt   <= '0;
      w1        <= 8'h00;
      w2        <= 8'h00;
      name_seen <= 1'b0;
      eof_armed <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      play_q   <= play;
      rewind_q <= rewind;

      if (mem_rd) begin
        if (mem_ack) begin
          mem_rd <= 1'b0;
          if (discard || rew_rise) begin
            mem_addr <= '0;
            discard  <= 1'b0;
          end else begin
            buf_valid <= 1'b1;
            buf_data  <= mem_data;
            mem_addr  <= mem_addr + 1'b1;
          end
        end else if (rew_rise) begin
          discard <= 1'b1;
        end
      end else if (rew_rise) begin
        mem_addr <= '0;
      end else if (fetch_ok && !buf_valid && mem_addr != end_addr) begin
        mem_rd <= 1'b1;
      end

      if (rew_rise) begin
        buf_valid <= 1'b0;
        sh_valid  <= 1'b0;
        sh_eof    <= 1'b0;
        phase     <= 1'b0;
        bit_idx   <= 3'd0;
        cnt       <= '0;
        gap_cnt   <= '0;
        w1        <= 8'h00;
        w2        <= 8'h00;
        name_seen <= 1'b0;
        eof_armed <= 1'b0;
        underrun  <= 1'b0;
      end else begin
        if (load) begin
          // The EOF decision is taken at load time but acted on only once
          // the byte's last half-cycle has gone out.
          buf_valid <= 1'b0;
          sh_valid  <= 1'b1;
          sh_data   <= buf_data;
          phase     <= 1'b0;
          bit_idx   <= 3'd0;
          cnt       <= '0;
          w2        <= w1;
          w1        <= buf_data;
          sh_eof    <= eof_armed & (w2 == 8'h00) & (w1 == 8'hFF) & (buf_data == 8'h55);
          if (win_gap)
            name_seen <= 1'b0;
          else if ({w2, w1, buf_data} == 24'h553C00)
            name_seen <= 1'b1;
          else if ({w2, w1, buf_data} == 24'h553CFF)
            eof_armed <= 1'b1;
        end else if (half_end) begin
          cnt <= '0;
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (bit_idx == 3'd7) begin
              sh_valid <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              sh_data <= {1'b0, sh_data[7:1]};
            end
          end
        end else if (ce && run_act && sh_valid) begin
          cnt <= cnt + 1'b1;
        end

        if (load && win_gap)
          gap_cnt <= '0;
        else if (ce && gap_act)
          gap_cnt <= gap_cnt + 1'b1;

        if (run_act && !sh_valid && !buf_valid && mem_addr != end_addr)
          underrun <= 1'b1;
      end
    end
  end

endmodule
